// File: rtl/rf_wb_arb_pkg.sv
// Shared widths, register-index types and round-robin helper
// for the register-file write-back arbiter.
package rf_wb_arb_pkg;

  localparam int NREQ_DEF = 3;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t REG_ZERO = '0;

  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker: first valid requester
// at or above ptr, wrapping modulo N.
module rf_rr_pick
  import rf_wb_arb_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = rr_wrap(int'(ptr) + k, N);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with busy scoreboard.
// RF_WB_ARB_BYPASS_EN adds commit-cycle forwarding ports.
module rf_wb_arbiter
  import rf_wb_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_addr,
  input  logic [ADDR_WIDTH-1:0]      chk_addr1,
  input  logic [ADDR_WIDTH-1:0]      chk_addr2,
  output logic                       chk_busy1,
  output logic                       chk_busy2,
`ifdef RF_WB_ARB_BYPASS_EN
  output logic                       fwd_valid1,
  output logic                       fwd_valid2,
  output logic [DATA_WIDTH-1:0]      fwd_data1,
  output logic [DATA_WIDTH-1:0]      fwd_data2,
`endif
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         gidx;
  logic [NREQ-1:0]       grant;
  logic                  any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NREGS-1:0]      busy;

  rf_rr_pick #(.N(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  assign req_ready = grant;

  always_comb begin
    sel_addr = req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data = req_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  // x0 writes are accepted but never reach the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any) begin
      rf_wen   <= (sel_addr != '0);
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_wen <= 1'b0;
    end
  end

  // set is written last so a same-edge issue beats the commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (rf_wen)
        busy[rf_waddr] <= 1'b0;
      if (iss_valid && iss_addr != '0)
        busy[iss_addr] <= 1'b1;
    end
  end

`ifdef RF_WB_ARB_BYPASS_EN
  logic hold1;
  logic hold2;

  assign fwd_valid1 = rf_wen && (rf_waddr == chk_addr1);
  assign fwd_valid2 = rf_wen && (rf_waddr == chk_addr2);
  assign fwd_data1  = rf_wdata;
  assign fwd_data2  = rf_wdata;
  assign hold1      = iss_valid && (iss_addr == chk_addr1);
  assign hold2      = iss_valid && (iss_addr == chk_addr2);
  assign chk_busy1  = busy[chk_addr1] && !(fwd_valid1 && !hold1);
  assign chk_busy2  = busy[chk_addr2] && !(fwd_valid2 && !hold2);
`else
  assign chk_busy1 = busy[chk_addr1];
  assign chk_busy2 = busy[chk_addr2];
`endif

endmodule
